// File: rtl/state_dump_reader.sv
// Read-back engine for the multi-cycle MIPS core: walks the register file and then
// data memory through their read ports and streams each word over valid/ready.
module state_dump_reader #(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32,
  parameter int MEM_WORDS = 64,
  parameter int IDX_W     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dump_regs,
  input  logic              dump_mem,
  output logic              busy,
  output logic              done,
  output logic [4:0]        reg_raddr,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic [IDX_W-1:0]  mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  output logic [IDX_W-1:0]  out_index
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;

  localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(REG_COUNT - 1);
  localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_WORDS - 1);

  logic [2:0]       state;
  logic             src;      // 0 = register file, 1 = data memory
  logic             en_mem;   // memory pass requested by the accepted start
  logic [IDX_W-1:0] index;
  logic [IDX_W-1:0] index_inc;

  assign index_inc = index + 1'b1;

  // Status decodes straight from the state register, so reset clears them with it.
  assign busy = (state != S_IDLE);
  assign done = (state == S_FINISH);

  // NOTE: reset is sampled on the clock edge only; rst is not in the sensitivity list.
  // NOTE: every state register uses <= so all updates see the pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      src       <= 1'b0;
      en_mem    <= 1'b0;
      index     <= '0;
      reg_raddr <= '0;
      mem_raddr <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
      out_index <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            en_mem <= dump_mem;
            index  <= '0;
            if (dump_regs) begin
              src       <= 1'b0;
              reg_raddr <= '0;
              state     <= S_FETCH;
            end else if (dump_mem) begin
              src       <= 1'b1;
              mem_raddr <= '0;
              state     <= S_FETCH;
            end else begin
              state <= S_FINISH;
            end
          end
        end

        // Address was loaded on entry; read data shows up during CAPTURE.
        S_FETCH: state <= S_CAPTURE;

        S_CAPTURE: begin
          out_data  <= src ? mem_rdata : reg_rdata;
          out_src   <= src;
          out_index <= index;
          out_valid <= 1'b1;
          state     <= S_SEND;
        end

        S_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!src && index != REG_LAST) begin
              index     <= index_inc;
              reg_raddr <= index_inc[4:0];
              state     <= S_FETCH;
            end else if (src && index != MEM_LAST) begin
              index     <= index_inc;
              mem_raddr <= index_inc;
              state     <= S_FETCH;
            end else if (!src && en_mem) begin
              src       <= 1'b1;
              index     <= '0;
              mem_raddr <= '0;
              state     <= S_FETCH;
            end else begin
              state <= S_FINISH;
            end
          end
        end

        S_FINISH: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_state_dump_reader.sv
// Directed bench for state_dump_reader: models both read ports with one-cycle
// latency and checks every streamed word, latency, busy/done and reset abort.
module tb_state_dump_reader;

  localparam int DATA_W    = 32;
  localparam int REG_COUNT = 32;
  localparam int MEM_WORDS = 64;
  localparam int IDX_W     = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              dump_regs = 1'b0;
  logic              dump_mem = 1'b0;
  logic              out_ready = 1'b0;
  logic              busy, done, out_valid, out_src;
  logic [4:0]        reg_raddr;
  logic [IDX_W-1:0]  mem_raddr, out_index;
  logic [DATA_W-1:0] reg_rdata, mem_rdata, out_data;

  logic [DATA_W-1:0] regs [REG_COUNT];
  logic [DATA_W-1:0] dmem [MEM_WORDS];

  int checks   = 0;
  int failures = 0;

  state_dump_reader #(
    .DATA_W(DATA_W), .REG_COUNT(REG_COUNT), .MEM_WORDS(MEM_WORDS), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .dump_regs(dump_regs), .dump_mem(dump_mem),
    .busy(busy), .done(done),
    .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src), .out_index(out_index)
  );

  always #5 clk = ~clk;

  // Synchronous-read port models: data follows the address by one cycle.
  always @(posedge clk) begin
    reg_rdata <= regs[reg_raddr];
    mem_rdata <= dmem[mem_raddr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered and left at posedge+1. mode 0: ready high; 1: random ready;
  // 2: ready high with start held high for the whole dump.
  task automatic run_dump(input string name, input logic dr, input logic dm, input int mode);
    logic              e_src  [$];
    int                e_idx  [$];
    logic [DATA_W-1:0] e_data [$];
    int n, c, got, done_cnt, done_cycle, first_valid, last_hs, busy_bad;
    int extra_done, extra_valid, extra_busy;
    logic held;
    logic [DATA_W-1:0] h_data;
    logic [IDX_W-1:0]  h_idx;
    logic              h_src;

    if (dr) for (int i = 0; i < REG_COUNT; i++) begin
      e_src.push_back(1'b0); e_idx.push_back(i); e_data.push_back(regs[i]);
    end
    if (dm) for (int i = 0; i < MEM_WORDS; i++) begin
      e_src.push_back(1'b1); e_idx.push_back(i); e_data.push_back(dmem[i]);
    end
    n = e_src.size();

    start = 1'b1; dump_regs = dr; dump_mem = dm; out_ready = 1'b1;
    @(posedge clk); #1;
    c = 1; got = 0; done_cnt = 0; done_cycle = -1; first_valid = -1;
    last_hs = -1; busy_bad = 0; held = 1'b0;
    h_data = '0; h_idx = '0; h_src = 1'b0;

    while (c < 2000 && done_cnt == 0) begin
      start     = (mode == 2);
      dump_regs = 1'b0;
      dump_mem  = 1'b0;
      out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (busy !== 1'b1) busy_bad++;
      if (out_valid === 1'b1) begin
        if (first_valid < 0) first_valid = c;
        if (held) begin
          check($sformatf("%s_hold_data_%0d", name, got), 64'(out_data), 64'(h_data));
          check($sformatf("%s_hold_idx_%0d", name, got), 64'(out_index), 64'(h_idx));
          check($sformatf("%s_hold_src_%0d", name, got), 64'(out_src), 64'(h_src));
        end
        if (out_ready) begin
          if (got < n) begin
            check($sformatf("%s_src_%0d", name, got), 64'(out_src), 64'(e_src[got]));
            check($sformatf("%s_idx_%0d", name, got), 64'(out_index), 64'(e_idx[got]));
            check($sformatf("%s_data_%0d", name, got), 64'(out_data), 64'(e_data[got]));
          end
          got++;
          last_hs = c;
          held = 1'b0;
        end else begin
          held = 1'b1; h_data = out_data; h_idx = out_index; h_src = out_src;
        end
      end else begin
        held = 1'b0;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cycle = c;
      end
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;

    check({name, "_done_seen"}, 64'(done_cnt), 64'(1));
    check({name, "_word_count"}, 64'(got), 64'(n));
    check({name, "_busy_during"}, 64'(busy_bad), 64'(0));
    if (n > 0)
      check({name, "_done_after_last"}, 64'(done_cycle), 64'(last_hs + 1));
    else
      check({name, "_no_valid"}, 64'(first_valid), 64'(-1));
    if (mode != 1) begin
      check({name, "_done_latency"}, 64'(done_cycle), 64'(3 * n + 1));
      if (n > 0) check({name, "_first_valid"}, 64'(first_valid), 64'(3));
    end

    extra_done = 0; extra_valid = 0; extra_busy = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done !== 1'b0) extra_done++;
      if (out_valid !== 1'b0) extra_valid++;
      if (busy !== 1'b0) extra_busy++;
      @(posedge clk); #1;
    end
    check({name, "_idle_done"}, 64'(extra_done), 64'(0));
    check({name, "_idle_valid"}, 64'(extra_valid), 64'(0));
    check({name, "_idle_busy"}, 64'(extra_busy), 64'(0));
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_busy"}, 64'(busy), 64'(0));
    check({name, "_done"}, 64'(done), 64'(0));
    check({name, "_valid"}, 64'(out_valid), 64'(0));
    check({name, "_src"}, 64'(out_src), 64'(0));
    check({name, "_data"}, 64'(out_data), 64'(0));
    check({name, "_index"}, 64'(out_index), 64'(0));
    check({name, "_reg_raddr"}, 64'(reg_raddr), 64'(0));
    check({name, "_mem_raddr"}, 64'(mem_raddr), 64'(0));
  endtask

  initial begin
    int found, bad;

    for (int i = 0; i < REG_COUNT; i++) regs[i] = '0;
    for (int i = 0; i < MEM_WORDS; i++) dmem[i] = '0;
    dmem[0] = 32'd1; dmem[2] = 32'd3; dmem[3] = 32'd4;

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_values("por");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Memory only: 64 words, done 193 cycles after start.
    run_dump("mem_only", 1'b0, 1'b1, 0);
    check("mem_only_mem_raddr_hold", 64'(mem_raddr), 64'(MEM_WORDS - 1));
    check("mem_only_reg_raddr_hold", 64'(reg_raddr), 64'(0));

    // Registers only with two preloaded values.
    regs[16] = 32'd5; regs[8] = 32'd7;
    run_dump("regs_only", 1'b1, 1'b0, 0);
    check("regs_only_reg_raddr_hold", 64'(reg_raddr), 64'(REG_COUNT - 1));

    // Both, with distinct words and a stalling sink.
    for (int i = 0; i < REG_COUNT; i++) regs[i] = 32'hA000_0000 + i;
    for (int i = 0; i < MEM_WORDS; i++) dmem[i] = 32'hB000_0000 + i;
    run_dump("both_rand", 1'b1, 1'b1, 1);

    // Nothing enabled: one busy cycle, one done pulse.
    run_dump("none", 1'b0, 1'b0, 0);

    // Start held high through the whole dump including FINISH.
    run_dump("start_spam", 1'b1, 1'b1, 2);

    // Reset while memory word 10 is being offered.
    start = 1'b1; dump_regs = 1'b1; dump_mem = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dump_regs = 1'b0; dump_mem = 1'b0;
    found = 0;
    for (int k = 0; k < 400 && found == 0; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_src === 1'b1 && out_index === IDX_W'(10)) found = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    rst = 1'b0;
    check("abort_reached_mem10", 64'(found), 64'(1));
    @(posedge clk); #1;
    check_reset_values("abort");
    @(posedge clk); #1;
    rst = 1'b1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    check("abort_quiet", 64'(bad), 64'(0));
    run_dump("after_abort", 1'b1, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
